// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the SpMV datapath: field layout, constants and
// accumulator state encoding.
package fp32_pkg;

  localparam int unsigned FP32_W     = 32;
  localparam int unsigned FP32_SIGN_W = 1;
  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned FP32_BIAS  = 127;

  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic [FP32_SIGN_W-1:0] sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MAN_W-1:0]  man;
  } fp32_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

endpackage

// File: rtl/fp32_add_ftz.sv
// Combinational FP32 adder: truncation rounding, flush-to-zero on denormals,
// +0 on exact cancellation, saturation to infinity on overflow.
module fp32_add_ftz
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  localparam int unsigned MANT_W = FP32_MAN_W + 1;
  localparam int unsigned LZ_W   = 5;

  // Leading-zero count over the 24-bit significand; 24 when all zero.
  function automatic logic [LZ_W-1:0] lzc24(input logic [MANT_W-1:0] v);
    lzc24 = LZ_W'(MANT_W);
    for (int i = 0; i < int'(MANT_W); i++) begin
      if (v[i]) lzc24 = LZ_W'(int'(MANT_W) - 1 - i);
    end
  endfunction

  fp32_t              fa, fb, op_big, op_small, res;
  logic               a_zero, b_zero, swap;
  logic [7:0]         ediff;
  logic [MANT_W-1:0]  m_big, m_small, m_small_al, sub_diff, norm;
  logic [MANT_W:0]    add_sum;
  logic [LZ_W-1:0]    lz;

  always_comb begin
    fa         = fp32_t'(a);
    fb         = fp32_t'(b);
    a_zero     = (fa.exp == '0);
    b_zero     = (fb.exp == '0);
    swap       = {fb.exp, fb.man} > {fa.exp, fa.man};
    op_big     = swap ? fb : fa;
    op_small   = swap ? fa : fb;
    m_big      = {1'b1, op_big.man};
    m_small    = {1'b1, op_small.man};
    ediff      = op_big.exp - op_small.exp;
    m_small_al = (ediff >= 8'(MANT_W)) ? '0 : (m_small >> ediff);
    add_sum    = {1'b0, m_big} + {1'b0, m_small_al};
    sub_diff   = m_big - m_small_al;
    lz         = lzc24(sub_diff);
    norm       = sub_diff << lz;
    res        = fp32_t'(FP32_ZERO);

    if (a_zero && b_zero) begin
      res = fp32_t'(FP32_ZERO);
    end else if (a_zero) begin
      res = fb;
    end else if (b_zero) begin
      res = fa;
    end else if (fa.sign == fb.sign) begin
      if (add_sum[MANT_W]) begin
        // Carry out: renormalise right by one, saturating at the top exponent.
        if (op_big.exp >= 8'd254) begin
          res = fp32_t'(FP32_INF);
          res.sign = op_big.sign;
        end else begin
          res.sign = op_big.sign;
          res.exp  = op_big.exp + 8'd1;
          res.man  = add_sum[MANT_W-1:1];
        end
      end else begin
        res.sign = op_big.sign;
        res.exp  = op_big.exp;
        res.man  = add_sum[FP32_MAN_W-1:0];
      end
    end else if (sub_diff == '0) begin
      res = fp32_t'(FP32_ZERO);
    end else if ({2'b00, op_big.exp} <= 10'(lz)) begin
      res = fp32_t'(FP32_ZERO);
    end else begin
      res.sign = op_big.sign;
      res.exp  = op_big.exp - 8'(lz);
      res.man  = norm[FP32_MAN_W-1:0];
    end
  end

  assign sum = res;

endmodule

// File: rtl/fp32_row_accumulator.sv
// Reduces a stream of FP32 partial sums to one result per matrix row and
// buffers the results with their row index in a small output FIFO.
module fp32_row_accumulator
  import fp32_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROW_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [ROW_W-1:0] out_row_idx,
  output logic             busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  acc_state_t        state, state_next;
  logic [31:0]       acc, acc_next, add_res, push_data;
  logic [ROW_W-1:0]  row_cnt;
  logic              accept, push, pop;

  logic [31:0]       mem_data [FIFO_DEPTH];
  logic [ROW_W-1:0]  mem_row  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  fp32_add_ftz u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_res)
  );

  assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state == ACCUM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Row-boundary decode: chooses the next state, accumulator and FIFO push.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    push       = 1'b0;
    push_data  = FP32_ZERO;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (in_empty) begin
            push      = 1'b1;
            push_data = FP32_ZERO;
          end else if (in_last) begin
            push      = 1'b1;
            push_data = in_data;
          end else begin
            acc_next   = in_data;
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (in_empty) begin
            push       = 1'b1;
            push_data  = acc;
            state_next = IDLE;
          end else if (in_last) begin
            push       = 1'b1;
            push_data  = add_res;
            state_next = IDLE;
          end else begin
            acc_next = add_res;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= FP32_ZERO;
      row_cnt <= '0;
    end else begin
      acc <= acc_next;
      if (push) row_cnt <= row_cnt + ROW_W'(1);
    end
  end

  // FIFO storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
      mem_row[wr_ptr]  <= row_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_data    = out_valid ? mem_data[rd_ptr] : FP32_ZERO;
  assign out_row_idx = out_valid ? mem_row[rd_ptr]  : '0;

endmodule

// File: doc/fp32_row_accumulator.md
Name: fp32_row_accumulator

Overview:
- Downstream consumer of the systolic MAC column. Takes a stream of FP32 partial sums, each tagged with row-boundary flags, and reduces every matrix row to a single FP32 result.
- Buffers completed row results in a small output FIFO and hands them to the result writer over a valid/ready handshake, together with a row index.
- Sits between the last systolic PE and the output-vector store in the SpMV datapath.

Parameters:
- FIFO_DEPTH, 4, number of completed row results buffered; power of two, at least 2.
- ROW_W, 16, width of the row index counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  32  FP32 partial sum.
- in_last  input  1  beat is the final contribution of the current row.
- in_empty  input  1  row has no nonzeros; in_data is ignored.
- out_valid  output  1  FIFO head holds a row result.
- out_ready  input  1  downstream accepts the head.
- out_data  output  32  FP32 row sum.
- out_row_idx  output  ROW_W  index of the row the result belongs to.
- busy  output  1  accumulator is mid-row (state ACCUM).

Behaviour:
- Reset values:
  - State IDLE; acc = 0; row counter = 0; FIFO empty.
  - in_ready = 1, out_valid = 0, out_data = 0, out_row_idx = 0, busy = 0.
  - Reset mid-row discards the partial acc and all buffered results.
- Handshake:
  - A beat transfers when in_valid && in_ready.
  - A pop occurs when out_valid && out_ready.
  - in_ready = (fifo_count != FIFO_DEPTH). It is computed from the registered count only and has no combinational path from out_ready.
- State machine (IDLE, ACCUM):
  - IDLE, accept, in_empty=1: push {0x00000000, row_cnt}; row_cnt++; stay in IDLE.
  - IDLE, accept, in_last=1: push {in_data, row_cnt}; row_cnt++; stay in IDLE. A single-element row passes through unchanged.
  - IDLE, accept, other: acc <= in_data; go to ACCUM.
  - ACCUM, accept, in_last=1 or in_empty=1: push {fpadd(acc, in_data), row_cnt}, or {acc, row_cnt} when in_empty=1; row_cnt++; go to IDLE.
  - ACCUM, accept, other: acc <= fpadd(acc, in_data).
  - No accept: hold all state.
- Latency: the beat carrying in_last is accepted at edge N; out_valid is high from N+1. Back-to-back single-beat rows sustain 1 result per cycle while out_ready=1.
- Simultaneous push and pop:
  - Count is unchanged and both occur in the same cycle.
  - When full, a push cannot happen because in_ready=0. A pop in that cycle raises in_ready on the next cycle.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. out_data/out_row_idx show the FIFO head and are 0 when empty.
- row_cnt is ROW_W bits and wraps from 2^ROW_W-1 to 0 silently.
- Arithmetic (fpadd):
  - FP32, truncation rounding.
  - Exponent 0 is treated as zero (flush-to-zero on inputs and outputs).
  - Exact cancellation gives +0 (0x00000000).
  - Full leading-zero normalisation after subtraction.
  - Exponent underflow flushes to zero; overflow saturates to ±0x7F800000.
  - NaN inputs are not supported; output is undefined.

Decomposition:
- Shared package fp32_pkg:
  - FP32 field widths (sign 1, exponent 8, mantissa 23), exponent bias 127.
  - Constants FP32_ZERO = 0x00000000 and FP32_INF = 0x7F800000.
- One sub-module, fp32_add_ftz: combinational FP32 adder implementing the rules above, including a 24-bit leading-zero count for normalisation.
- The FIFO stays inline: a 48-bit-wide (ROW_W=16) register array plus pointers.

Test Plan:
- Rows [1.0, 2.0, last 3.0]: beats 0x3F800000, 0x40000000, 0x40400000 (last) with out_ready=1 -> one result 0x40C00000 (6.0), row_idx 0, out_valid one cycle after the last beat.
- Single-beat row 0x3FC00000 (last), then in_empty beat -> results 0x3FC00000 idx 0, then 0x00000000 idx 1, back to back.
- Cancellation row [0x3F800000, last 0xBF800000] -> 0x00000000; row [0x40000000, last 0xBF000000] -> 0x3FC00000 (1.5).
- out_ready=0, push 5 single-beat rows -> in_ready drops after the 4th accept; release out_ready -> idx 0..4 emerge in order, none lost or duplicated.
- Assert reset while in ACCUM after 0x3F800000 -> busy=0, out_valid=0, then row [last 0x40000000] emits 0x40000000 idx 0.
- ROW_W=2: send 5 single-beat rows -> out_row_idx sequence 0, 1, 2, 3, 0.
